// File: rtl/mac_4bit_seq.sv
// Sequencer for the 4-bit eFPGA MATHB MAC: streams DOT_LEN operand/coefficient
// beats into the accumulator, then captures the selected result slice.
module mac_4bit_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             MAC_ACC_CLK,
  input  logic             acc_ff_rst,
  input  logic             START,
  input  logic [LEN_W-1:0] DOT_LEN,
  input  logic [5:0]       CFG_OUT_SEL,
  input  logic             CFG_TC,
  input  logic             CFG_SAT,
  input  logic             CFG_RND,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       IN_OPER,
  input  logic [3:0]       IN_COEF,
  output logic [3:0]       MAC_OPER_DATA,
  output logic [3:0]       MAC_COEF_DATA,
  output logic             EFPGA_MATHB_CLK_EN,
  output logic             MAC_ACC_CLEAR,
  output logic             MAC_ACC_RND,
  output logic             MAC_ACC_SAT,
  output logic [5:0]       MAC_OUT_SEL,
  output logic             MAC_TC,
  input  logic [3:0]       MAC_OUT,
  output logic [3:0]       RES_DATA,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic [5:0]       out_sel_q;
  logic             tc_q;
  logic             sat_q;
  logic             rnd_q;
  logic [3:0]       res_q;
  logic             res_valid_q;
  logic             accept;
  logic             first_beat;

  assign accept     = IN_VALID && (state == ACCUM);
  assign first_beat = accept && (beat_cnt == '0);

  // Operands go straight through so the MAC accumulates on the accepting edge.
  assign MAC_OPER_DATA      = IN_OPER;
  assign MAC_COEF_DATA      = IN_COEF;
  assign EFPGA_MATHB_CLK_EN = accept;
  assign MAC_ACC_CLEAR      = first_beat && !rnd_q;
  assign MAC_ACC_RND        = first_beat && rnd_q;
  assign IN_READY           = (state == ACCUM);
  assign BUSY               = (state != IDLE);
  assign MAC_OUT_SEL        = out_sel_q;
  assign MAC_TC             = tc_q;
  assign MAC_ACC_SAT        = sat_q;
  assign RES_DATA           = res_q;
  assign RES_VALID          = res_valid_q;

  always_ff @(posedge MAC_ACC_CLK or posedge acc_ff_rst) begin
    if (acc_ff_rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      len_q       <= '0;
      out_sel_q   <= '0;
      tc_q        <= 1'b0;
      sat_q       <= 1'b0;
      rnd_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START && (DOT_LEN != '0)) begin
            len_q     <= DOT_LEN;
            out_sel_q <= CFG_OUT_SEL;
            tc_q      <= CFG_TC;
            sat_q     <= CFG_SAT;
            rnd_q     <= CFG_RND;
            beat_cnt  <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Stops at len_q, so a full-scale DOT_LEN never wraps the counter.
            beat_cnt <= beat_cnt + ONE;
            if (beat_cnt == (len_q - ONE)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          res_q       <= MAC_OUT;
          res_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
